fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch stage; drives the single instruction-memory read port.
- Produces the per-cycle {pc, instr, interrupt} triple that the fetch/decode pipeline register captures on the next rising edge.
- Owns the PC register, the reset-vector and interrupt-vector load sequences, branch redirection, stall bubbles and the pending-interrupt latch.

Parameters:
- RESET_VEC_ADDR, 32'd0: word address of the reset vector. High half is at this address, low half at +1.
- INT_VEC_ADDR, 32'd2: word address of the interrupt vector. High half is at this address, low half at +1.
- NOP_INSTR, 16'h0000: encoding injected as a bubble.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- o_imem_addr, output, 32: instruction memory word address (combinational).
- i_imem_data, input, 16: instruction memory read data. Asynchronous read, valid in the same cycle as o_imem_addr.
- i_stall, input, 1: hazard freeze. PC is held and a bubble is emitted.
- i_branch_taken, input, 1: redirect request from a downstream stage.
- i_branch_target, input, 32: redirect target PC.
- i_interrupt, input, 1: external interrupt request (pulse or level).
- o_pc, output, 32: PC associated with o_instr (combinational).
- o_instr, output, 16: instruction to the fetch/decode buffer (combinational).
- o_interrupt, output, 1: one-cycle marker telling downstream stages to start interrupt entry.

Behaviour:
- Registered state:
  - state: VEC_HI, VEC_LO, RUN, INT_HI, INT_LO.
  - pc[31:0].
  - vec_hi[15:0]: temporary for the vector high half.
  - int_pend: pending-interrupt latch.
- Reset (any state, mid-sequence included):
  - state<=VEC_HI, pc<=0, vec_hi<=0, int_pend<=0.
  - Outputs in the reset cycle are the combinational values for the current state. The first registered behaviour after reset is VEC_HI.
- VEC_HI: o_imem_addr=RESET_VEC_ADDR; vec_hi<=i_imem_data; go to VEC_LO.
- VEC_LO: o_imem_addr=RESET_VEC_ADDR+1; pc<={vec_hi,i_imem_data}; go to RUN.
- INT_HI / INT_LO: identical sequence using INT_VEC_ADDR and INT_VEC_ADDR+1; INT_LO returns to RUN.
- In all four vector states:
  - o_instr=NOP_INSTR, o_interrupt=0, o_pc=pc.
  - i_stall and i_branch_taken are ignored.
- RUN: o_imem_addr=pc. Per-cycle priority, highest first:
  1. Branch (i_branch_taken=1): pc<=i_branch_target; o_instr=NOP_INSTR (wrong-path word flushed); o_pc=pc; o_interrupt=0.
  2. Stall (i_stall=1): pc held; o_instr=NOP_INSTR; o_pc=pc; o_interrupt=0.
  3. Interrupt entry (int_pend=1):
     - o_interrupt=1, o_instr=NOP_INSTR.
     - o_pc=pc is the return address; the instruction at pc is not consumed.
     - int_pend<=0; state<=INT_HI; pc held.
  4. Normal fetch: o_instr=i_imem_data; o_pc=pc; pc<=pc+1; o_interrupt=0.
- Pending-interrupt latch:
  - int_pend<=1 on any cycle with i_interrupt=1, in every state except reset.
  - A set in the same cycle as the clear in priority 3 leaves int_pend=1, so a second interrupt is taken after the vector load.
  - Multiple requests while pending collapse into one.
- PC arithmetic: 32-bit unsigned, word (16-bit) granularity. pc+1 wraps 32'hFFFF_FFFF->32'h0000_0000.
- Simultaneous events:
  - Branch+interrupt: branch wins; interrupt is taken on the next eligible RUN cycle with o_pc=branch target.
  - Stall+interrupt: stall wins; interrupt is taken on the first unstalled cycle.
  - Interrupt during VEC_HI/VEC_LO: stays pending and is taken on the first RUN cycle.
- o_interrupt is never asserted for two consecutive cycles.

Test Plan:
- Reset vector: M[0]=16'h0000, M[1]=16'h0010, M[16..18]=h1111,h2222,h3333; pulse i_reset for 1 cycle -> 2 cycles of NOP with addr 0 then 1; then o_pc=16, o_instr=h1111; o_pc=17, o_instr=h2222; o_pc=18, o_instr=h3333.
- Branch: in RUN at pc=17, assert i_branch_taken with target 32'h40 for 1 cycle -> that cycle o_instr=NOP, o_pc=17; next cycle o_pc=32'h40, o_instr=M[64].
- Stall: i_stall high 3 cycles at pc=18 -> 3 NOPs with o_pc=18, pc frozen; on release o_instr=M[18], then o_pc=19.
- Interrupt: M[2]=0, M[3]=16'h0100; pulse i_interrupt at pc=20 -> next RUN cycle o_interrupt=1, o_pc=20 or 21 per timing, NOP; then 2 NOP vector cycles (addr 2, 3); then o_pc=32'h100. Also check branch+interrupt in the same cycle: o_interrupt appears one cycle later with o_pc=target.
- Wrap and reset mid-sequence: branch to 32'hFFFF_FFFF -> the following fetch has o_pc=0. Assert i_reset during INT_LO -> int_pend cleared, restart at VEC_HI, no o_interrupt afterwards.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reset/interrupt vector loads, branch redirect,
// stall bubbles and the pending-interrupt latch; drives the single imem read port.
module fetch_stage #(
    parameter logic [31:0] RESET_VEC_ADDR = 32'd0,
    parameter logic [31:0] INT_VEC_ADDR   = 32'd2,
    parameter logic [15:0] NOP_INSTR      = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [15:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_interrupt,
    output logic [31:0] o_pc,
    output logic [15:0] o_instr,
    output logic        o_interrupt
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [2:0] {
        VEC_HI = 3'd0,
        VEC_LO = 3'd1,
        RUN    = 3'd2,
        INT_HI = 3'd3,
        INT_LO = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    pc_next;
    logic [INSTR_W-1:0]   vec_hi;
    logic [INSTR_W-1:0]   vec_hi_next;
    logic                 int_pend;
    logic                 int_pend_next;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= VEC_HI;
            pc       <= '0;
            vec_hi   <= '0;
            int_pend <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            vec_hi   <= vec_hi_next;
            int_pend <= int_pend_next;
        end
    end

    // Next-state logic; a new request in the clearing cycle keeps the latch set
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        vec_hi_next   = vec_hi;
        int_pend_next = int_pend | i_interrupt;
        case (state)
            VEC_HI: begin
                vec_hi_next = i_imem_data;
                state_next  = VEC_LO;
            end
            VEC_LO: begin
                pc_next    = {vec_hi, i_imem_data};
                state_next = RUN;
            end
            INT_HI: begin
                vec_hi_next = i_imem_data;
                state_next  = INT_LO;
            end
            INT_LO: begin
                pc_next    = {vec_hi, i_imem_data};
                state_next = RUN;
            end
            RUN: begin
                if (i_branch_taken) begin
                    pc_next = i_branch_target;
                end else if (i_stall) begin
                    pc_next = pc;
                end else if (int_pend) begin
                    int_pend_next = i_interrupt;
                    state_next    = INT_HI;
                end else begin
                    pc_next = pc + ADDR_W'(1);
                end
            end
            default: state_next = VEC_HI;
        endcase
    end

    // Output logic
    always_comb begin
        o_imem_addr = pc;
        o_pc        = pc;
        o_instr     = NOP_INSTR;
        o_interrupt = 1'b0;
        case (state)
            VEC_HI: o_imem_addr = RESET_VEC_ADDR;
            VEC_LO: o_imem_addr = RESET_VEC_ADDR + ADDR_W'(1);
            INT_HI: o_imem_addr = INT_VEC_ADDR;
            INT_LO: o_imem_addr = INT_VEC_ADDR + ADDR_W'(1);
            RUN: begin
                if (!i_branch_taken && !i_stall) begin
                    if (int_pend) begin
                        o_interrupt = 1'b1;
                    end else begin
                        o_instr = i_imem_data;
                    end
                end
            end
            default: o_imem_addr = pc;
        endcase
    end

endmodule
